rvvi_depacketizer: RTL and testbench

- Receive side of the RVVI-over-Ethernet trace link: consumes a 32-bit AXI4-Stream of frames from the MAC receive path and reassembles the {rvvi, FrameCount} record built by the transmit packetizer.
- Filters frames on destination MAC and EthType, recognises header-only acknowledge frames, and checks frame-count sequence.
- Drops runt and overlong frames.
- Sits between the MAC RX FIFO and the host-side trace consumer or loopback checker.

---
 rtl/rvvi_pkg.sv | 22 ++
 rtl/rvvi_word_assembler.sv | 25 ++
 rtl/rvvi_depacketizer.sv | 201 ++++++++++++++++++++
 tb/tb_rvvi_depacketizer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_pkg.sv
// Shared frame layout constants and state encoding for the RVVI trace-link receiver.
package rvvi_pkg;

  // Frame geometry for the default record widths.
  localparam int unsigned NEAR        = 96 + 16 + 64 + 632;
  localparam int unsigned FRAME_WORDS = (NEAR + 32 - NEAR % 32) / 32;

  // Header word positions within a frame.
  localparam int unsigned W_SRC0 = 0;
  localparam int unsigned W_SRC1 = 1;
  localparam int unsigned W_DST  = 2;
  localparam int unsigned W_TYPE = 3;
  localparam int unsigned W_FC0  = 4;

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_HOLD, S_DROP} stateT;

  // Word count of a frame; always rounds up by 1..32 bits, as the transmitter does.
  function automatic int unsigned frameWords(input int unsigned near);
    return (near + 32 - near % 32) / 32;
  endfunction

endpackage

// File: rtl/rvvi_word_assembler.sv
// Frame assembly register: stores 32-bit words at their word-index position.
module rvvi_word_assembler #(
  parameter int unsigned NUM_WORDS = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wrEn,
  input  logic [9:0]              wordIndex,
  input  logic [31:0]             wordIn,
  output logic [NUM_WORDS*32-1:0] frame
);

  // Indexed word write; clear empties the register once a record is consumed.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      frame <= '0;
    end else if (wrEn) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wordIndex == 10'(i)) frame[i*32 +: 32] <= wordIn;
      end
    end
  end

endmodule

// File: rtl/rvvi_depacketizer.sv
// RVVI-over-Ethernet receiver: filters frames and reassembles {rvvi, FrameCount}.
module rvvi_depacketizer
  import rvvi_pkg::*;
#(
  parameter int unsigned RVVI_WIDTH        = 632,
  parameter int unsigned FRAME_COUNT_WIDTH = 64,
  parameter int unsigned ETH_HEAD_WIDTH    = 96,
  parameter int unsigned RVVI_PREFIX_PAD   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  InAxisTdata,
  input  logic [3:0]                   InAxisTkeep,
  input  logic                         InAxisTvalid,
  input  logic                         InAxisTlast,
  output logic                         InAxisTready,
  input  logic [47:0]                  LocalMac,
  input  logic [15:0]                  EthType,
  input  logic [15:0]                  AckType,
  output logic [RVVI_WIDTH-1:0]        rvvi,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic                         RvviValid,
  input  logic                         RvviReady,
  output logic                         AckValid,
  output logic                         SeqErr,
  output logic [15:0]                  DropCount
);

  localparam int unsigned NUM_WORDS  =
      frameWords(ETH_HEAD_WIDTH + RVVI_PREFIX_PAD + FRAME_COUNT_WIDTH + RVVI_WIDTH);
  localparam int unsigned FRAME_BITS = NUM_WORDS * 32;
  localparam int unsigned FC_LSB     = W_FC0 * 32;
  localparam int unsigned RVVI_LSB   = FC_LSB + FRAME_COUNT_WIDTH;
  localparam int unsigned PAD_LSB    = RVVI_LSB + RVVI_WIDTH;
  localparam logic [9:0]  LAST_IDX   = 10'(NUM_WORDS - 1);

  stateT                        state, nextState;
  logic [9:0]                   wordIdx;
  logic [47:0]                  dstMac;
  logic                         malformed, ackPending, expValid;
  logic [FRAME_COUNT_WIDTH-1:0] expected;
  logic [FRAME_BITS-1:0]        frame;
  logic                         xfer, badFrame, hdrMatch, isAck;
  logic                         dropInc, ackFire, ackDefer, holdEntry, wrEn, clearFrame;
  logic                         unusedBits;

  assign InAxisTready = !reset && (state != S_HOLD);
  assign RvviValid    = !reset && (state == S_HOLD);
  assign xfer         = InAxisTvalid && InAxisTready;
  // A zero keep anywhere in the frame poisons the whole frame.
  assign badFrame     = malformed || (InAxisTkeep == 4'b0000);
  assign hdrMatch     = (dstMac == LocalMac) && (InAxisTdata[15:0] == EthType) && !badFrame;
  assign isAck        = (InAxisTdata[31:16] == AckType);

  assign FrameCount = frame[FC_LSB +: FRAME_COUNT_WIDTH];
  assign rvvi       = frame[RVVI_LSB +: RVVI_WIDTH];
  // Header words are never stored and pad bits are ignored.
  assign unusedBits = ^{frame[FC_LSB-1:0], frame[FRAME_BITS-1:PAD_LSB]};

  rvvi_word_assembler #(
    .NUM_WORDS (NUM_WORDS)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (clearFrame),
    .wrEn      (wrEn),
    .wordIndex (wordIdx),
    .wordIn    (InAxisTdata),
    .frame     (frame)
  );

  // Next-state decode and per-frame event strobes.
  always_comb begin
    nextState  = state;
    dropInc    = 1'b0;
    ackFire    = 1'b0;
    ackDefer   = 1'b0;
    holdEntry  = 1'b0;
    wrEn       = 1'b0;
    clearFrame = 1'b0;
    unique case (state)
      S_HDR: begin
        if (xfer) begin
          if (wordIdx == 10'(W_TYPE)) begin
            if (!hdrMatch) begin
              if (InAxisTlast) dropInc = 1'b1;
              else             nextState = S_DROP;
            end else if (isAck) begin
              if (InAxisTlast) begin
                ackFire = 1'b1;
              end else begin
                ackDefer  = 1'b1;
                nextState = S_DROP;
              end
            end else if (InAxisTlast) begin
              dropInc = 1'b1;
            end else begin
              nextState = S_PAYLOAD;
            end
          end else if (InAxisTlast) begin
            dropInc = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          wrEn = 1'b1;
          if (wordIdx == LAST_IDX) begin
            if (!InAxisTlast) begin
              nextState = S_DROP;
            end else if (badFrame) begin
              dropInc   = 1'b1;
              nextState = S_HDR;
            end else begin
              holdEntry = 1'b1;
              nextState = S_HOLD;
            end
          end else if (InAxisTlast) begin
            dropInc   = 1'b1;
            nextState = S_HDR;
          end
        end
      end
      S_HOLD: begin
        if (RvviValid && RvviReady) begin
          nextState  = S_HDR;
          clearFrame = 1'b1;
        end
      end
      S_DROP: begin
        if (xfer && InAxisTlast) begin
          nextState = S_HDR;
          if (ackPending && !badFrame) ackFire = 1'b1;
          else                         dropInc = 1'b1;
        end
      end
      default: nextState = S_HDR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR;
    else       state <= nextState;
  end

  // Word index and malformed flag, both restart at every tlast.
  always_ff @(posedge clk) begin
    if (reset) begin
      wordIdx   <= '0;
      malformed <= 1'b0;
    end else if (xfer) begin
      wordIdx   <= InAxisTlast ? 10'd0 : wordIdx + 10'd1;
      malformed <= InAxisTlast ? 1'b0 : (malformed || (InAxisTkeep == 4'b0000));
    end
  end

  // Destination MAC is split across w1/w2 and compared when w3 arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      dstMac <= '0;
    end else if (xfer && (state == S_HDR)) begin
      if (wordIdx == 10'(W_SRC1)) dstMac[15:0]  <= InAxisTdata[31:16];
      if (wordIdx == 10'(W_DST))  dstMac[47:16] <= InAxisTdata;
    end
  end

  // Acknowledge pulse; an ack frame longer than its header is acked at its tlast.
  always_ff @(posedge clk) begin
    if (reset) begin
      AckValid   <= 1'b0;
      ackPending <= 1'b0;
    end else begin
      AckValid <= ackFire;
      if (ackDefer)                                       ackPending <= 1'b1;
      else if ((state == S_DROP) && xfer && InAxisTlast)  ackPending <= 1'b0;
    end
  end

  // Frame-count sequence check on each delivered record.
  always_ff @(posedge clk) begin
    if (reset) begin
      SeqErr   <= 1'b0;
      expValid <= 1'b0;
      expected <= '0;
    end else begin
      SeqErr <= holdEntry && expValid && (FrameCount != expected);
      if (holdEntry) begin
        expected <= FrameCount + {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};
        expValid <= 1'b1;
      end
    end
  end

  // Saturating discarded-frame counter.
  always_ff @(posedge clk) begin
    if (reset)                                DropCount <= '0;
    else if (dropInc && DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
  end

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer with hand-built frames.
module tb_rvvi_depacketizer;

  localparam int unsigned RW  = 632;
  localparam int unsigned FCW = 64;
  localparam int          NW  = 26;

  localparam logic [47:0] LMAC   = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BADMAC = 48'h02_11_22_33_44_56;
  localparam logic [47:0] SMAC   = 48'h0A_BB_CC_DD_EE_FF;
  localparam logic [15:0] ETYPE  = 16'h88B5;
  localparam logic [15:0] ATYPE  = 16'h00AC;
  localparam logic [15:0] DTYPE  = 16'h0000;

  logic           clk = 1'b0;
  logic           reset;
  logic [31:0]    InAxisTdata;
  logic [3:0]     InAxisTkeep;
  logic           InAxisTvalid;
  logic           InAxisTlast;
  logic           InAxisTready;
  logic [RW-1:0]  rvvi;
  logic [FCW-1:0] FrameCount;
  logic           RvviValid;
  logic           RvviReady;
  logic           AckValid;
  logic           SeqErr;
  logic [15:0]    DropCount;

  rvvi_depacketizer dut (
    .clk          (clk),
    .reset        (reset),
    .InAxisTdata  (InAxisTdata),
    .InAxisTkeep  (InAxisTkeep),
    .InAxisTvalid (InAxisTvalid),
    .InAxisTlast  (InAxisTlast),
    .InAxisTready (InAxisTready),
    .LocalMac     (LMAC),
    .EthType      (ETYPE),
    .AckType      (ATYPE),
    .rvvi         (rvvi),
    .FrameCount   (FrameCount),
    .RvviValid    (RvviValid),
    .RvviReady    (RvviReady),
    .AckValid     (AckValid),
    .SeqErr       (SeqErr),
    .DropCount    (DropCount)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errCount   = 0;

  task automatic checkEq(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkRvvi(input int unsigned seed);
    logic [639:0] t;
    for (int k = 0; k < 20; k++) t[k*32 +: 32] = {8'hA5, seed[7:0], 16'(k * 7 + 3)};
    return t[RW-1:0];
  endfunction

  // Output monitor, sampled 1 time unit after the falling edge.
  int             validCycles = 0;
  int             ackCycles   = 0;
  int             seqCycles   = 0;
  int             nDel        = 0;
  int             stableBad   = 0;
  logic [FCW-1:0] gotFc   [0:15];
  logic [RW-1:0]  gotRvvi [0:15];
  logic           prevValid = 1'b0;
  logic [RW-1:0]  prevRvvi  = '0;

  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (RvviValid) validCycles++;
      if (AckValid)  ackCycles++;
      if (SeqErr)    seqCycles++;
      if (prevValid && RvviValid && (rvvi !== prevRvvi)) stableBad++;
      if (RvviValid && RvviReady) begin
        if (nDel < 16) begin
          gotFc[nDel]   = FrameCount;
          gotRvvi[nDel] = rvvi;
        end
        nDel++;
      end
    end
    prevValid = RvviValid;
    prevRvvi  = rvvi;
  end

  int stalls = 0;

  // Called at a falling edge; returns at the falling edge after the word transfers.
  task automatic sendWord(input logic [31:0] d, input logic l, input logic [3:0] k);
    int w;
    w = 0;
    InAxisTdata  = d;
    InAxisTlast  = l;
    InAxisTkeep  = k;
    InAxisTvalid = 1'b1;
    #1;
    while (!InAxisTready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    stalls += w;
    if (w >= 200) begin
      checkEq("ready_timeout", {639'b0, InAxisTready}, 640'd1);
      InAxisTvalid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [63:0] fc, input int unsigned seed, input logic [47:0] dst,
                           input logic [15:0] af, input int nWords, input int kz,
                           input bit withLast);
    logic [831:0] v;
    v      = {8'h00, mkRvvi(seed), fc, af, ETYPE, dst, SMAC};
    stalls = 0;
    for (int i = 0; i < nWords; i++) begin
      sendWord((i < NW) ? v[i*32 +: 32] : (32'hDEAD_0000 | 32'(i)),
               withLast && (i == nWords - 1), (i == kz) ? 4'h0 : 4'hF);
    end
    InAxisTvalid = 1'b0;
    InAxisTlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b0, b1;

  initial begin
    reset        = 1'b1;
    InAxisTdata  = '0;
    InAxisTkeep  = 4'hF;
    InAxisTvalid = 1'b0;
    InAxisTlast  = 1'b0;
    RvviReady    = 1'b1;

    // Reset state
    idle(3);
    #1 checkEq("ready_in_reset", {639'b0, InAxisTready}, 640'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    checkEq("rst_valid", {639'b0, RvviValid}, 640'd0);
    checkEq("rst_ack", {639'b0, AckValid}, 640'd0);
    checkEq("rst_seqerr", {639'b0, SeqErr}, 640'd0);
    checkEq("rst_drop", {624'b0, DropCount}, 640'd0);
    checkEq("rst_fc", {576'b0, FrameCount}, 640'd0);
    checkEq("rst_rvvi", {8'b0, rvvi}, 640'd0);
    checkEq("rst_ready", {639'b0, InAxisTready}, 640'd1);
    @(negedge clk);

    // One good frame, FrameCount 5
    b0 = validCycles;
    sendFrame(64'd5, 1, LMAC, DTYPE, NW, -1, 1'b1);
    #2 checkEq("good_valid_latency", {639'b0, RvviValid}, 640'd1);
    idle(3);
    #2;
    checkEq("good_valid_cycles", 640'(validCycles - b0), 640'd1);
    checkEq("good_ndel", 640'(nDel), 640'd1);
    checkEq("good_fc", {576'b0, gotFc[0]}, 640'd5);
    checkEq("good_rvvi", {8'b0, gotRvvi[0]}, {8'b0, mkRvvi(1)});
    checkEq("good_drop", {624'b0, DropCount}, 640'd0);
    checkEq("good_seqerr", 640'(seqCycles), 640'd0);
    @(negedge clk);

    // Destination MAC mismatch
    b0 = validCycles;
    sendFrame(64'd6, 2, BADMAC, DTYPE, NW, -1, 1'b1);
    idle(3);
    #2;
    checkEq("mac_stalls", 640'(stalls), 640'd0);
    checkEq("mac_drop", {624'b0, DropCount}, 640'd1);
    checkEq("mac_novalid", 640'(validCycles - b0), 640'd0);
    @(negedge clk);

    // Header-only acknowledge frame
    b0 = validCycles;
    b1 = ackCycles;
    sendFrame(64'd0, 0, LMAC, ATYPE, 4, -1, 1'b1);
    idle(3);
    #2;
    checkEq("ack_pulse", 640'(ackCycles - b1), 640'd1);
    checkEq("ack_novalid", 640'(validCycles - b0), 640'd0);
    checkEq("ack_drop", {624'b0, DropCount}, 640'd1);
    @(negedge clk);

    // Sequence: 6, 7 continue from 5; 9 skips 8
    sendFrame(64'd6, 3, LMAC, DTYPE, NW, -1, 1'b1);
    sendFrame(64'd7, 4, LMAC, DTYPE, NW, -1, 1'b1);
    idle(3);
    #2 checkEq("seq_in_order", 640'(seqCycles), 640'd0);
    @(negedge clk);
    sendFrame(64'd9, 5, LMAC, DTYPE, NW, -1, 1'b1);
    idle(3);
    #2;
    checkEq("seq_gap_err", 640'(seqCycles), 640'd1);
    checkEq("seq_ndel", 640'(nDel), 640'd4);
    checkEq("seq_fc9", {576'b0, gotFc[3]}, 640'd9);
    checkEq("seq_rvvi9", {8'b0, gotRvvi[3]}, {8'b0, mkRvvi(5)});
    @(negedge clk);

    // Runt, overlong and zero-keep frames, then a good one
    sendFrame(64'd10, 6, LMAC, DTYPE, 11, -1, 1'b1);
    sendFrame(64'd10, 6, LMAC, DTYPE, 28, -1, 1'b1);
    sendFrame(64'd10, 6, LMAC, DTYPE, NW, 8, 1'b1);
    idle(3);
    #2;
    checkEq("bad_drop", {624'b0, DropCount}, 640'd4);
    checkEq("bad_ndel", 640'(nDel), 640'd4);
    @(negedge clk);
    sendFrame(64'd10, 9, LMAC, DTYPE, NW, -1, 1'b1);
    idle(3);
    #2;
    checkEq("after_bad_ndel", 640'(nDel), 640'd5);
    checkEq("after_bad_fc", {576'b0, gotFc[4]}, 640'd10);
    checkEq("after_bad_rvvi", {8'b0, gotRvvi[4]}, {8'b0, mkRvvi(9)});
    checkEq("after_bad_seq", 640'(seqCycles), 640'd1);
    @(negedge clk);

    // Backpressure: consumer stalls while the next frame is offered
    RvviReady = 1'b0;
    sendFrame(64'd11, 10, LMAC, DTYPE, NW, -1, 1'b1);
    fork
      sendFrame(64'd12, 11, LMAC, DTYPE, NW, -1, 1'b1);
      begin
        idle(19);
        #2;
        checkEq("bp_ready_low", {639'b0, InAxisTready}, 640'd0);
        checkEq("bp_valid_high", {639'b0, RvviValid}, 640'd1);
        checkEq("bp_hold_fc", {576'b0, FrameCount}, 640'd11);
        checkEq("bp_hold_rvvi", {8'b0, rvvi}, {8'b0, mkRvvi(10)});
        @(negedge clk);
        RvviReady = 1'b1;
      end
    join
    idle(3);
    #2;
    checkEq("bp_stalled", 640'(stalls >= 19), 640'd1);
    checkEq("bp_ndel", 640'(nDel), 640'd7);
    checkEq("bp_fc11", {576'b0, gotFc[5]}, 640'd11);
    checkEq("bp_fc12", {576'b0, gotFc[6]}, 640'd12);
    checkEq("bp_rvvi12", {8'b0, gotRvvi[6]}, {8'b0, mkRvvi(11)});
    checkEq("bp_stable", 640'(stableBad), 640'd0);
    checkEq("bp_seq", 640'(seqCycles), 640'd1);
    @(negedge clk);

    // Reset in the middle of a frame
    sendFrame(64'd13, 12, LMAC, DTYPE, 12, -1, 1'b0);
    reset = 1'b1;
    #2 checkEq("mid_rst_ready", {639'b0, InAxisTready}, 640'd0);
    @(negedge clk);
    #2;
    checkEq("mid_rst_valid", {639'b0, RvviValid}, 640'd0);
    checkEq("mid_rst_drop", {624'b0, DropCount}, 640'd0);
    checkEq("mid_rst_fc", {576'b0, FrameCount}, 640'd0);
    checkEq("mid_rst_rvvi", {8'b0, rvvi}, 640'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    b1 = seqCycles;
    sendFrame(64'd100, 13, LMAC, DTYPE, NW, -1, 1'b1);
    idle(3);
    #2;
    checkEq("post_rst_ndel", 640'(nDel), 640'd8);
    checkEq("post_rst_fc", {576'b0, gotFc[7]}, 640'd100);
    checkEq("post_rst_rvvi", {8'b0, gotRvvi[7]}, {8'b0, mkRvvi(13)});
    checkEq("post_rst_seq", 640'(seqCycles - b1), 640'd0);
    checkEq("post_rst_drop", {624'b0, DropCount}, 640'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
